digit_ram_writer: RTL

- Write-side counterpart of the display read path.
- Collects BCD digits from a keypad/entry source into a two-digit buffer (tens, ones).
- On commit, writes the pair into the digit RAM as two consecutive words at the selected number slot (tens at base, ones at base+1), using the RAM's we/adr/value port.
- The display mux later reads those two words back for the seven-segment decoder.

---
 rtl/digit_pkg.sv | 27 ++
 rtl/digit_entry_buf.sv | 48 ++++
 rtl/digit_ram_writer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/digit_pkg.sv
// Shared constants and types for the digit RAM write path.
package digit_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 5;
  localparam int unsigned DIGIT_W = 4;

  // Digit code the seven-segment decoder renders as all segments off.
  localparam logic [DIGIT_W-1:0] BLANK = 4'd11;

  // Base addresses of the two number slots in the digit RAM.
  localparam logic [ADDR_W-1:0] SLOT_A = 3'b000;
  localparam logic [ADDR_W-1:0] SLOT_B = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    WR_TENS,
    WR_ONES,
    DONE
  } wr_state_t;

  // BCD range check for a keypad digit.
  function automatic logic digit_in_range(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_entry_buf.sv
// Two-digit entry buffer: shifts in BCD digits (tens <- ones <- new),
// keeps only the last two, and counts entered digits saturating at 2.
module digit_entry_buf
  import digit_pkg::*;
#(
  parameter logic [3:0] BLANK_CODE = digit_pkg::BLANK
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       shift_en_i,
  input  logic       clr_i,
  input  logic [3:0] digit_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic [1:0] count_o,
  output logic       digit_ok_o
);

  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [1:0] count_q;

  assign digit_ok_o = digit_in_range(digit_i);

  // Clear wins over a shift; out-of-range digits never enter the buffer.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      tens_q  <= BLANK_CODE;
      ones_q  <= BLANK_CODE;
      count_q <= '0;
    end else if (clr_i) begin
      tens_q  <= BLANK_CODE;
      ones_q  <= BLANK_CODE;
      count_q <= '0;
    end else if (shift_en_i && digit_ok_o) begin
      tens_q <= ones_q;
      ones_q <= digit_i;
      if (count_q != 2'd2) begin
        count_q <= count_q + 2'd1;
      end
    end
  end

  assign tens_o  = tens_q;
  assign ones_o  = ones_q;
  assign count_o = count_q;

endmodule

// File: rtl/digit_ram_writer.sv
// Collects a two-digit number from the keypad and, on commit, writes it to
// the digit RAM as two consecutive words (tens at slot base, ones at base+1).
module digit_ram_writer #(
  parameter int unsigned        ADDR_W = digit_pkg::ADDR_W,
  parameter int unsigned        DATA_W = digit_pkg::DATA_W,
  parameter int unsigned        BLANK  = 32'(digit_pkg::BLANK),
  parameter logic [ADDR_W-1:0]  SLOT_A = digit_pkg::SLOT_A,
  parameter logic [ADDR_W-1:0]  SLOT_B = digit_pkg::SLOT_B
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              digit_valid,
  input  logic [3:0]        digit,
  input  logic              clear,
  input  logic              commit,
  input  logic [ADDR_W-1:0] slot,
  output logic              we,
  output logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import digit_pkg::*;

  wr_state_t         state_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] value_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              err_d;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        ones_w_q;

  logic [3:0]        buf_tens;
  logic [3:0]        buf_ones;
  logic [1:0]        buf_count;
  logic              buf_digit_ok;
  logic              buf_shift;
  logic              buf_clr;

  logic              in_idle;
  logic              slot_ok;
  logic              commit_ok;

  digit_entry_buf #(
    .BLANK_CODE (4'(BLANK))
  ) u_buf (
    .clk        (clk),
    .rst_i      (reset),
    .shift_en_i (buf_shift),
    .clr_i      (buf_clr),
    .digit_i    (digit),
    .tens_o     (buf_tens),
    .ones_o     (buf_ones),
    .count_o    (buf_count),
    .digit_ok_o (buf_digit_ok)
  );

  // Input arbitration: commit > clear > digit, and any strobe while busy is an error.
  // DONE accepts input like IDLE: the buffer was already blanked on entry to DONE.
  always_comb begin
    in_idle   = (state_q == IDLE) || (state_q == DONE);
    slot_ok   = (slot == SLOT_A) || (slot == SLOT_B);
    commit_ok = in_idle && commit && slot_ok && (buf_count != '0);
    buf_shift = in_idle && digit_valid && !clear && !commit;
    buf_clr   = (in_idle && clear && !commit) || (state_q == WR_ONES);
    err_d     = 1'b0;
    if (in_idle) begin
      if (commit) begin
        err_d = !commit_ok || digit_valid || clear;
      end else begin
        err_d = digit_valid && !clear && !buf_digit_ok;
      end
    end else begin
      err_d = digit_valid || clear || commit;
    end
  end

  // Write sequencer with registered RAM port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      value_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      base_q   <= '0;
      ones_w_q <= '0;
    end else begin
      err_q  <= err_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          we_q   <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
          if (commit_ok) begin
            // Tens word goes out directly; ones is held for the next cycle.
            state_q  <= WR_TENS;
            we_q     <= 1'b1;
            busy_q   <= 1'b1;
            adr_q    <= slot;
            value_q  <= DATA_W'(buf_tens);
            base_q   <= slot;
            ones_w_q <= buf_ones;
          end
        end
        WR_TENS: begin
          state_q <= WR_ONES;
          we_q    <= 1'b1;
          busy_q  <= 1'b1;
          adr_q   <= base_q + ADDR_W'(1);
          value_q <= DATA_W'(ones_w_q);
        end
        WR_ONES: begin
          state_q <= DONE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign we    = we_q;
  assign adr   = adr_q;
  assign value = value_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
